// File: rtl/data_mem_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory responder (slave).
interface data_mem_ctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store controller: lane alignment, sign extension, bus handshake with timeout.
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              err_o,
    data_mem_ctrl_if.master   bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic             access_c;
    logic             illegal_c;
    logic             misaligned_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      shifted_c;
    logic [31:0]      load_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Request decode and store-lane formatting
    always_comb begin
        access_c     = mem_read | mem_write;
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        wdata_c      = 32'h0;
        if (mem_write)
            illegal_c = funct3[2] | (funct3[1:0] == 2'b11);
        else
            illegal_c = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        if (funct3[1:0] == 2'b01)
            misaligned_c = addr[0];
        else if (funct3[1:0] == 2'b10)
            misaligned_c = (addr[1:0] != 2'b00);
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata;
            end
        endcase
    end

    // Load lane extraction from the returned word
    always_comb begin
        shifted_c = bus.bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_c = {24'h0, shifted_c[7:0]};
            3'b101:  load_c = {16'h0, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    assign cnt_inc_c = cnt + CNT_W'(1);
    // Hold is combinational so the requesting instruction freezes in its first MEM cycle
    assign stall_o   = (state == REQ) || ((state == IDLE) && access_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            rdata_o         <= 32'h0;
            err_o           <= 1'b0;
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= 32'h0;
            bus.bus_wdata_o <= 32'h0;
            bus.bus_be_o    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (access_c) begin
                        if (illegal_c || misaligned_c) begin
                            state   <= DONE;
                            err_o   <= 1'b1;
                            rdata_o <= 32'h0;
                        end else begin
                            state           <= REQ;
                            cnt             <= '0;
                            f3_q            <= funct3;
                            off_q           <= addr[1:0];
                            bus.bus_req_o   <= 1'b1;
                            bus.bus_we_o    <= mem_write;
                            bus.bus_addr_o  <= {addr[31:2], 2'b00};
                            bus.bus_be_o    <= mem_write ? be_c : 4'b0000;
                            bus.bus_wdata_o <= mem_write ? wdata_c : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state         <= DONE;
                        bus.bus_req_o <= 1'b0;
                        if (!bus.bus_we_o)
                            rdata_o <= load_c;
                    end else begin
                        cnt <= cnt_inc_c;
                        if (cnt_inc_c == TIMEOUT_CNT) begin
                            state         <= DONE;
                            bus.bus_req_o <= 1'b0;
                            err_o         <= 1'b1;
                            rdata_o       <= 32'h0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    err_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
